// File: rtl/inst_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response FIFO to decode.
// States: FETCH | issue and collect ; DRAIN | discard responses of flushed requests
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t          state, state_next;
  logic [31:0]     pc, pc_next;
  logic [CW-1:0]   outstanding, outstanding_next;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [31:0]     fifo_pc   [DEPTH];
  logic [31:0]     fifo_inst [DEPTH];
  logic [31:0]     tag_q     [DEPTH];
  logic [CW:0]     credit_sum;
  logic            pop, accept, rsp, write_en;
  logic            unused_pc_bits;

  assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inst_valid       = (count != '0);
    pop              = inst_valid & inst_ready;
    credit_sum       = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
    imem_req_valid   = rst_n & (state == FETCH) & (credit_sum < DEPTH_W) & ~redirect_valid;
    imem_addr        = pc;
    accept           = imem_req_valid & imem_req_ready;
    // a response with nothing outstanding is a protocol error and is dropped
    rsp              = imem_rsp_valid & (outstanding != '0);
    write_en         = rsp & (state == FETCH) & ~redirect_valid;
    outstanding_next = outstanding + CW'(accept) - CW'(rsp);
    inst_out         = inst_valid ? fifo_inst[rd_ptr] : '0;
    inst_pc          = inst_valid ? fifo_pc[rd_ptr]   : '0;

    pc_next = pc;
    if (redirect_valid)
      pc_next = {redirect_pc[31:2], 2'b00};
    else if (accept)
      pc_next = pc + 32'd4;

    state_next = state;
    if (redirect_valid)
      state_next = (outstanding_next != '0) ? DRAIN : FETCH;
    else if (state == DRAIN && outstanding_next == '0)
      state_next = FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      state       <= FETCH;
    end else begin
      pc          <= pc_next;
      outstanding <= outstanding_next;
      state       <= state_next;
      if (accept) begin
        tag_q[tag_wr] <= pc;
        tag_wr        <= ptr_inc(tag_wr);
      end
      if (redirect_valid) begin
        // accept is never set with a redirect, so clearing tag_wr here is safe
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        tag_rd <= '0;
        tag_wr <= '0;
      end else begin
        if (write_en) begin
          fifo_pc[wr_ptr]   <= tag_q[tag_rd];
          fifo_inst[wr_ptr] <= imem_rsp_data;
          wr_ptr            <= ptr_inc(wr_ptr);
          tag_rd            <= ptr_inc(tag_rd);
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(write_en) - CW'(pop);
      end
    end
  end

endmodule
